// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous up/down modulo-MODULUS counter built from one
// JK flip-flop stage per state bit. Every stage's J/K pair is derived
// combinationally from the current count, the mode (load/count/hold) and
// the next-state target.
//
// Ports:
//   clk    - clock, all state changes on posedge
//   rst_n  - synchronous active-low reset (q=0, wrap=0, err=0)
//   en     - count enable
//   up_dn  - direction, 1 = up, 0 = down
//   load   - synchronous parallel load, priority over en
//   din    - load value
//   q      - current count, one bit per JK stage
//   tc     - Mealy terminal count (high in the cycle before a wrap edge)
//   wrap   - registered one-cycle pulse after a wrapping edge
//   err    - sticky out-of-range-load flag, cleared only by reset

// Single JK stage: q(next) = J & ~q | ~K & q, synchronous active-low reset.
module jk_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);
  logic q_d, q_q;

  always_comb q_d = (j & ~q_q) | (~k & q_q);

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);
  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("jk_mod_counter: need 2 <= MODULUS <= 2**WIDTH");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_cur;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic             set_mode;   // J/K drive target directly (load or wrap)
  logic             cnt_mode;   // J = K = toggle mask
  logic             at_max, at_zero, load_bad;
  logic             wrap_d, wrap_q;
  logic             err_d,  err_q;

  assign at_max   = (q_cur == MAX_V);
  assign at_zero  = (q_cur == '0);
  assign load_bad = ({1'b0, din} >= MOD_W);

  // Next-state target and mode; priority load > en > hold (reset lives in
  // the flops themselves).
  always_comb begin
    target   = q_cur;
    set_mode = 1'b0;
    cnt_mode = 1'b0;
    wrap_d   = 1'b0;
    err_d    = err_q;
    if (load) begin
      set_mode = 1'b1;
      target   = load_bad ? '0 : din;
      err_d    = err_q | load_bad;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          set_mode = 1'b1;
          target   = '0;
          wrap_d   = 1'b1;
        end else begin
          cnt_mode = 1'b1;
          target   = q_cur + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          set_mode = 1'b1;
          target   = MAX_V;
          wrap_d   = 1'b1;
        end else begin
          cnt_mode = 1'b1;
          target   = q_cur - WIDTH'(1);
        end
      end
    end
  end

  // Per-bit J/K: a counting step toggles exactly the bits that differ from
  // the target; load/wrap force each stage to the target bit.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (set_mode) begin
      j_vec = target;
      k_vec = ~target;
    end else if (cnt_mode) begin
      j_vec = q_cur ^ target;
      k_vec = q_cur ^ target;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (q_cur[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_cur;
  assign wrap = wrap_q;
  assign err  = err_q;
  assign tc   = rst_n & en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));
endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;
  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, load;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc, wrap, err;

  int n_cmp = 0;
  int n_bad = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .din(din), .q(q), .tc(tc), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, en, up_dn, load;
    logic [3:0] din;
    logic       tc;     // expected before the edge
    logic [3:0] q;      // expected after the edge
    logic       wrap, err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, e, u, l, input int d,
                              input logic t, input int qq, input logic w, er);
    vec_t v;
    v.rst_n = r; v.en = e; v.up_dn = u; v.load = l; v.din = 4'(d);
    v.tc = t; v.q = 4'(qq); v.wrap = w; v.err = er;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input logic r, e, u, l, input logic [3:0] d);
    rst_n = r; en = e; up_dn = u; load = l; din = d;
  endtask

  task automatic post_edge(input string tag, input int eq, input int ew, input int ee);
    @(posedge clk); #1;
    chk({tag, ".q"}, int'(q), eq);
    chk({tag, ".wrap"}, int'(wrap), ew);
    chk({tag, ".err"}, int'(err), ee);
  endtask

  initial begin
    drive(0, 0, 1, 0, 0);

    // reset
    add(0,0,1,0,0,  0,0,0,0);
    add(0,0,1,0,0,  0,0,0,0);
    // up-count 1..9, 0, 1, 2
    add(1,1,1,0,0,  0,1,0,0);
    add(1,1,1,0,0,  0,2,0,0);
    add(1,1,1,0,0,  0,3,0,0);
    add(1,1,1,0,0,  0,4,0,0);
    add(1,1,1,0,0,  0,5,0,0);
    add(1,1,1,0,0,  0,6,0,0);
    add(1,1,1,0,0,  0,7,0,0);
    add(1,1,1,0,0,  0,8,0,0);
    add(1,1,1,0,0,  0,9,0,0);
    add(1,1,1,0,0,  1,0,1,0);
    add(1,1,1,0,0,  0,1,0,0);
    add(1,1,1,0,0,  0,2,0,0);
    // reset overrides en, then down-count 9..0, 9
    add(0,1,1,0,0,  0,0,0,0);
    add(1,1,0,0,0,  1,9,1,0);
    add(1,1,0,0,0,  0,8,0,0);
    add(1,1,0,0,0,  0,7,0,0);
    add(1,1,0,0,0,  0,6,0,0);
    add(1,1,0,0,0,  0,5,0,0);
    add(1,1,0,0,0,  0,4,0,0);
    add(1,1,0,0,0,  0,3,0,0);
    add(1,1,0,0,0,  0,2,0,0);
    add(1,1,0,0,0,  0,1,0,0);
    add(1,1,0,0,0,  0,0,0,0);
    add(1,1,0,0,0,  1,9,1,0);
    // loads and sticky err
    add(1,0,1,1,7,  0,7,0,0);
    add(1,0,1,1,12, 0,0,0,1);
    add(1,0,1,1,3,  0,3,0,1);
    add(0,0,1,0,0,  0,0,0,0);
    // load boundaries: 9 legal, 10 illegal, 15 with en set
    add(1,0,1,1,9,  0,9,0,0);
    add(1,0,1,1,10, 0,0,0,1);
    add(1,1,0,1,15, 0,0,0,1);
    add(0,1,1,1,7,  0,0,0,0);
    // priority: load beats en, then hold
    add(1,0,1,1,5,  0,5,0,0);
    add(1,1,1,1,2,  0,2,0,0);
    add(1,0,1,0,0,  0,2,0,0);
    add(1,0,1,0,0,  0,2,0,0);
    add(1,0,1,0,0,  0,2,0,0);
    // tc needs en: q=0 down with en=0
    add(1,0,0,1,0,  0,0,0,0);
    add(1,0,0,0,0,  0,0,0,0);
    // load at q=9 with en: no wrap
    add(1,0,1,1,9,  0,9,0,0);
    add(1,1,1,1,4,  0,4,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].en, tbl[i].up_dn, tbl[i].load, tbl[i].din);
      #1;
      chk($sformatf("v%0d.tc", i), int'(tc), int'(tbl[i].tc));
      post_edge($sformatf("v%0d", i), int'(tbl[i].q), int'(tbl[i].wrap), int'(tbl[i].err));
    end

    // Mealy timing: tc follows up_dn with no clock edge
    @(negedge clk); drive(1, 0, 1, 1, 9);
    post_edge("mealy_ld", 9, 0, 0);
    @(negedge clk); drive(1, 1, 1, 0, 0);
    #1 chk("mealy.tc_up", int'(tc), 1);
    #2 up_dn = 1'b0;
    #1 chk("mealy.tc_dn", int'(tc), 0);
    post_edge("mealy", 8, 0, 0);

    // Reset mid-count at q=6, then resume from 0
    @(negedge clk); drive(1, 0, 1, 1, 5);
    post_edge("mid_ld", 5, 0, 0);
    @(negedge clk); drive(1, 1, 1, 0, 0);
    post_edge("mid_cnt", 6, 0, 0);
    @(negedge clk); drive(0, 1, 1, 0, 0);
    #1 chk("mid_rst.tc", int'(tc), 0);
    post_edge("mid_rst", 0, 0, 0);
    @(negedge clk); drive(1, 1, 1, 0, 0);
    post_edge("mid_rel", 1, 0, 0);

    // Reset at q=9 with en up: tc masked, no wrap pulse
    @(negedge clk); drive(1, 0, 1, 1, 9);
    post_edge("rst9_ld", 9, 0, 0);
    @(negedge clk); drive(0, 1, 1, 0, 0);
    #1 chk("rst9.tc", int'(tc), 0);
    post_edge("rst9", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
